// File: rtl/read_iq.sv
// Byte-stream to paired I/Q writer: gathers I_lo, I_hi, Q_lo, Q_hi from a FWFT byte FIFO,
// scales each 16-bit sample by 2^QUANT_BITS and pushes I and Q into their FIFOs together.
module read_iq #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int QUANT_BITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         in_rd_en,
  input  logic                         in_empty,
  input  logic [BYTE_WIDTH-1:0]        in_dout,
  output logic                         i_wr_en,
  output logic                         q_wr_en,
  input  logic                         i_full,
  input  logic                         q_full,
  output logic signed [DATA_WIDTH-1:0] i_din,
  output logic signed [DATA_WIDTH-1:0] q_din
);

  localparam int SAMPLE_W = 2 * BYTE_WIDTH;

  typedef enum logic {READ, WRITE} state_t;

  state_t                state, state_next;
  logic [1:0]            idx, idx_next;
  logic [BYTE_WIDTH-1:0] byte_p0 [4];
  logic                  consume;
  logic                  wr;

  // Exact for any legal parameter set: SAMPLE_W + QUANT_BITS must not exceed DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] quantize(
    input logic [BYTE_WIDTH-1:0] hi,
    input logic [BYTE_WIDTH-1:0] lo
  );
    logic signed [SAMPLE_W-1:0]   s;
    logic signed [DATA_WIDTH-1:0] ext;
    s   = $signed({hi, lo});
    ext = DATA_WIDTH'(s);
    return ext <<< QUANT_BITS;
  endfunction

  always_comb begin
    state_next = state;
    idx_next   = idx;
    in_rd_en   = 1'b0;
    consume    = 1'b0;
    wr         = 1'b0;
    i_din      = '0;
    q_din      = '0;
    case (state)
      READ: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          consume  = 1'b1;
          idx_next = idx + 2'd1;
          if (idx == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        if (!i_full && !q_full) begin
          wr         = 1'b1;
          i_din      = quantize(byte_p0[1], byte_p0[0]);
          q_din      = quantize(byte_p0[3], byte_p0[2]);
          state_next = READ;
        end
      end
      default: state_next = READ;
    endcase
    // Reset wins over everything: no byte is popped and a pending sample is dropped.
    if (rst) begin
      in_rd_en = 1'b0;
      consume  = 1'b0;
      wr       = 1'b0;
      i_din    = '0;
      q_din    = '0;
    end
  end

  assign i_wr_en = wr;
  assign q_wr_en = wr;

  // Stage p0: byte capture into the slot chosen by the running byte index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= READ;
      idx   <= 2'd0;
      for (int k = 0; k < 4; k++) byte_p0[k] <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (consume) byte_p0[idx] <= in_dout;
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Scoreboard bench for read_iq: expected I/Q pairs are queued as bytes are driven and
// compared whenever the DUT strobes its write enables.
module tb_read_iq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rd_en;
  logic        in_empty;
  logic [7:0]  in_dout;
  logic        i_wr_en, q_wr_en;
  logic        i_full, q_full;
  logic [31:0] i_din, q_din;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int i_cnt = 0;
  int q_cnt = 0;
  int last_wr_cyc = -1;
  bit stream_mode = 1'b0;
  logic [63:0] exp_q [$];

  read_iq #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .QUANT_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .i_wr_en(i_wr_en), .q_wr_en(q_wr_en),
    .i_full(i_full), .q_full(q_full),
    .i_din(i_din), .q_din(q_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Golden model: sample value times 1024, computed in integer arithmetic.
  function automatic logic [63:0] model(input logic [15:0] iv, input logic [15:0] qv);
    int a, b;
    a = int'($signed(iv)) * 1024;
    b = int'($signed(qv)) * 1024;
    return {32'(a), 32'(b)};
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      chk("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
      chk("rst_wr_en", {30'd0, i_wr_en, q_wr_en}, 32'd0);
      chk("rst_din", i_din | q_din, 32'd0);
    end else begin
      if (in_rd_en) begin
        rd_cnt++;
        chk("rd_while_empty", {31'd0, in_empty}, 32'd0);
      end
      if (i_wr_en || q_wr_en) begin
        chk("wr_pair", {31'd0, q_wr_en}, {31'd0, i_wr_en});
        if (i_wr_en) i_cnt++;
        if (q_wr_en) q_cnt++;
        wr_cnt++;
        chk("exp_avail", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("i_din", i_din, e[63:32]);
          chk("q_din", q_din, e[31:0]);
        end
        if (stream_mode && last_wr_cyc >= 0) chk("spacing", cyc - last_wr_cyc, 32'd5);
        last_wr_cyc = cyc;
      end else begin
        chk("i_idle", i_din, 32'd0);
        chk("q_idle", q_din, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int at);
    bit got;
    if (gap > 0) begin
      in_empty = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_dout  = b;
    in_empty = 1'b0;
    got = 1'b0;
    at = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (in_rd_en) begin
        got = 1'b1;
        at = cyc;
      end
      @(posedge clk);
      #1;
    end
    chk("byte_wait", {31'd0, got}, 32'd1);
    in_empty = 1'b1;
  endtask

  task automatic send_sample(input logic [15:0] iv, input logic [15:0] qv,
                             input int gap, output int first_at);
    int at;
    send_byte(iv[7:0], gap, first_at);
    send_byte(iv[15:8], gap, at);
    send_byte(qv[7:0], gap, at);
    send_byte(qv[15:8], gap, at);
  endtask

  initial begin
    int fa, rd0, wr0, rel;
    logic [15:0] ri, rq;
    rst = 1'b1; in_empty = 1'b0; in_dout = 8'h55; i_full = 1'b0; q_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic pair with latency check
    exp_q.push_back({32'h0000_0400, 32'hFFFF_FC00});
    send_sample(16'h0001, 16'hFFFF, 0, fa);
    @(posedge clk); #1;
    chk("basic_latency", last_wr_cyc - fa, 32'd4);

    // Extremes
    exp_q.push_back({32'hFE00_0000, 32'h01FF_FC00});
    send_sample(16'h8000, 16'h7FFF, 0, fa);
    @(posedge clk); #1;

    // Starved input: 3 empty cycles before each byte
    rd0 = rd_cnt; wr0 = wr_cnt;
    exp_q.push_back({32'h0000_0400, 32'hFFFF_FC00});
    send_sample(16'h0001, 16'hFFFF, 3, fa);
    repeat (3) @(posedge clk); #1;
    chk("starved_rd_cnt", rd_cnt - rd0, 32'd4);
    chk("starved_wr_cnt", wr_cnt - wr0, 32'd1);

    // Backpressure on Q with the next byte already waiting
    q_full = 1'b1;
    exp_q.push_back(model(16'h1234, 16'hFEDC));
    send_sample(16'h1234, 16'hFEDC, 0, fa);
    in_dout = 8'h21; in_empty = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_rd", rd_cnt - rd0, 32'd0);
    chk("stall_wr", wr_cnt - wr0, 32'd0);
    q_full = 1'b0;
    rel = cyc;
    @(posedge clk); #1;
    chk("bp_wr_cyc", last_wr_cyc, rel);
    exp_q.push_back(model(16'h4321, 16'h00FF));
    send_sample(16'h4321, 16'h00FF, 0, fa);
    @(posedge clk); #1;

    // Reset mid-sample
    send_byte(8'h01, 0, fa);
    send_byte(8'h00, 0, fa);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({32'h0000_0800, 32'h0000_0C00});
    send_sample(16'h0002, 16'h0003, 0, fa);
    @(posedge clk); #1;

    // Reset while stalled in WRITE drops the sample
    i_full = 1'b1;
    wr0 = wr_cnt;
    send_sample(16'h7777, 16'h8888, 0, fa);
    i_full = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_write_drop", wr_cnt - wr0, 32'd0);
    exp_q.push_back(model(16'hABCD, 16'h0102));
    send_sample(16'hABCD, 16'h0102, 0, fa);
    @(posedge clk); #1;

    // Streaming: 100 random pairs back to back
    stream_mode = 1'b1;
    last_wr_cyc = -1;
    wr0 = wr_cnt;
    for (int p = 0; p < 100; p++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      exp_q.push_back(model(ri, rq));
      send_sample(ri, rq, 0, fa);
    end
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
      @(posedge clk); #1;
    end
    stream_mode = 1'b0;
    chk("stream_writes", wr_cnt - wr0, 32'd100);
    chk("drain", exp_q.size(), 32'd0);
    chk("iq_counts", i_cnt, q_cnt);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
